// File: rtl/vga_pkg.sv
// VGA timing package: 640x480@60 defaults, sprite defaults,
// the timing bundle carried down the output pipe, and clog2.
package vga_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;

   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int IMG_W_D      = 64;
   localparam int IMG_H_D      = 48;
   localparam int SCALE_LOG2_D = 3;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic valid;
      logic line_start;
      logic frame_start;
   } vga_tim_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ce-gated shift register with an async clear value;
// depth 0 collapses to a plain wire.
module vga_delay_line #(
   parameter int               WIDTH = 1,
   parameter int               DEPTH = 1,
   parameter logic [WIDTH-1:0] CLR   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      assign q = d;
   end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      // shift one stage per pixel enable
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= CLR;
         end else if (ce) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
         end
      end

      assign q = sr[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with a scaled sprite window and a
// delayed timing pipe aligned to the image-memory read.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_D,
   parameter int H_FP       = H_FP_D,
   parameter int H_SYNC     = H_SYNC_D,
   parameter int H_BP       = H_BP_D,
   parameter int V_ACTIVE   = V_ACTIVE_D,
   parameter int V_FP       = V_FP_D,
   parameter int V_SYNC     = V_SYNC_D,
   parameter int V_BP       = V_BP_D,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int IMG_W      = IMG_W_D,
   parameter int IMG_H      = IMG_H_D,
   parameter int SCALE_LOG2 = SCALE_LOG2_D,
   parameter int OUT_DELAY  = 1,
   localparam int IDX_W     = clog2(IMG_W * IMG_H)
) (
   input  logic             clk25,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [9:0]       win_x,
   input  logic [9:0]       win_y,
   output logic [9:0]       x,
   output logic [9:0]       y,
   output logic [IDX_W-1:0] pixel_index,
   output logic             in_window,
   output logic             hsync,
   output logic             vsync,
   output logic             valid,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int VS_BEG  = V_ACTIVE + V_FP;

   localparam logic [10:0] SPAN_W = 11'(IMG_W << SCALE_LOG2);
   localparam logic [10:0] SPAN_H = 11'(IMG_H << SCALE_LOG2);

   localparam vga_tim_t TIM_RST = '{
      hsync: ~HS_POL, vsync: ~VS_POL, default: 1'b0};

   logic [9:0] h, v;
   logic [9:0] wx, wy;
   logic       h_last, v_last;

   assign h_last = (h == 10'(H_TOTAL - 1));
   assign v_last = (v == 10'(V_TOTAL - 1));

   // raster counters; the window is latched at end of frame
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         h  <= '0;
         v  <= '0;
         wx <= '0;
         wy <= '0;
      end else if (ce) begin
         if (h_last) begin
            h <= '0;
            if (v_last) begin
               v  <= '0;
               wx <= win_x;
               wy <= win_y;
            end else begin
               v <= v + 10'd1;
            end
         end else begin
            h <= h + 10'd1;
         end
      end
   end

   logic [10:0]      h11, v11, wx11, wy11;
   logic [10:0]      rel_x, rel_y;
   logic [31:0]      idx_full;
   logic             vis_c, inw_c;
   logic [IDX_W-1:0] idx_c;
   vga_tim_t         tim_c;

   assign h11   = {1'b0, h};
   assign v11   = {1'b0, v};
   assign wx11  = {1'b0, wx};
   assign wy11  = {1'b0, wy};
   assign rel_x = h11 - wx11;
   assign rel_y = v11 - wy11;

   assign vis_c = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));

   assign inw_c = vis_c
      && (h11 >= wx11) && (h11 < wx11 + SPAN_W)
      && (v11 >= wy11) && (v11 < wy11 + SPAN_H);

   assign idx_full = 32'(rel_y >> SCALE_LOG2) * 32'(IMG_W)
                   + 32'(rel_x >> SCALE_LOG2);
   assign idx_c    = inw_c ? idx_full[IDX_W-1:0] : '0;

   assign tim_c.hsync =
      ((h >= 10'(HS_BEG)) && (h < 10'(HS_BEG + H_SYNC)))
      ? HS_POL : ~HS_POL;
   assign tim_c.vsync =
      ((v >= 10'(VS_BEG)) && (v < 10'(VS_BEG + V_SYNC)))
      ? VS_POL : ~VS_POL;
   assign tim_c.valid       = vis_c;
   assign tim_c.line_start  = (h == '0);
   assign tim_c.frame_start = (h == '0) && (v == '0);

   vga_tim_t tim_s1, tim_q;

   // first output stage: coordinates, address and timing
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         x           <= '0;
         y           <= '0;
         pixel_index <= '0;
         in_window   <= 1'b0;
         tim_s1      <= TIM_RST;
      end else if (ce) begin
         x           <= h;
         y           <= v;
         pixel_index <= idx_c;
         in_window   <= inw_c;
         tim_s1      <= tim_c;
      end
   end

   vga_delay_line #(
      .WIDTH ($bits(vga_tim_t)),
      .DEPTH (OUT_DELAY),
      .CLR   (TIM_RST)
   ) u_tim_dly (
      .clk   (clk25),
      .rst_n (rst_n),
      .ce    (ce),
      .d     (tim_s1),
      .q     (tim_q)
   );

   assign hsync       = tim_q.hsync;
   assign vsync       = tim_q.vsync;
   assign valid       = tim_q.valid;
   assign line_start  = tim_q.line_start & ce;
   assign frame_start = tim_q.frame_start & ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster,
// checked against an arithmetic pixel-number model.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
   localparam int VA = 48, VFP = 2, VSY = 2, VBP = 3;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam int IW = 8, IH = 6, SL = 1;
   localparam int OD = 3;
   localparam bit HSP = 1'b0, VSP = 1'b1;
   localparam int XW = clog2(IW * IH);
   localparam int SW = IW << SL, SH = IH << SL;

   logic          clk25 = 1'b0;
   logic          rst_n, ce;
   logic [9:0]    win_x, win_y;
   logic [9:0]    x, y;
   logic [XW-1:0] pixel_index;
   logic          in_window, hsync, vsync, valid;
   logic          line_start, frame_start;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(HSP), .VS_POL(VSP),
      .IMG_W(IW), .IMG_H(IH), .SCALE_LOG2(SL),
      .OUT_DELAY(OD)
   ) dut (
      .clk25(clk25), .rst_n(rst_n), .ce(ce),
      .win_x(win_x), .win_y(win_y),
      .x(x), .y(y), .pixel_index(pixel_index),
      .in_window(in_window),
      .hsync(hsync), .vsync(vsync), .valid(valid),
      .line_start(line_start), .frame_start(frame_start)
   );

   always #5 clk25 = ~clk25;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] tim_exp(input int pd);
      int   hh, vv;
      logic hs, vs;
      hh = pd % HT;
      vv = (pd / HT) % VT;
      hs = (hh >= HA + HFP && hh < HA + HFP + HSY) ? HSP : ~HSP;
      vs = (vv >= VA + VFP && vv < VA + VFP + VSY) ? VSP : ~VSP;
      return {hs, vs, (hh < HA && vv < VA),
              (hh == 0), (hh == 0 && vv == 0)};
   endfunction

   int phase = 0;
   int exp_period = 0;

   // model state
   int n = 0;
   int cwx = 0, cwy = 0;
   int ex_x = 0, ex_y = 0, ex_idx = 0;
   bit ex_inw = 1'b0;
   int cyc = 0;
   int last_fs = -1;
   int seen_phase = 0;

   initial begin : monitor
      int p, hh, vv;
      bit vis;
      logic [4:0] tim;
      forever begin
         @(posedge clk25);
         cyc++;
         if (!rst_n) begin
            n = 0; cwx = 0; cwy = 0;
            ex_x = 0; ex_y = 0; ex_idx = 0; ex_inw = 1'b0;
         end else if (ce) begin
            p  = n;
            hh = p % HT;
            vv = (p / HT) % VT;
            vis = (hh < HA) && (vv < VA);
            ex_x = hh;
            ex_y = vv;
            ex_inw = vis && hh >= cwx && hh < cwx + SW
                         && vv >= cwy && vv < cwy + SH;
            ex_idx = ex_inw ?
               ((vv - cwy) >> SL) * IW + ((hh - cwx) >> SL) : 0;
            if (p % FRAME == FRAME - 1) begin
               cwx = int'(win_x);
               cwy = int'(win_y);
            end
            n++;
         end
         @(negedge clk25);
         chk("stage1", {x, y, pixel_index, in_window},
             {10'(ex_x), 10'(ex_y), XW'(ex_idx), ex_inw});
         if (n >= 1 + OD) tim = tim_exp(n - 1 - OD);
         else             tim = {~HSP, ~VSP, 3'b000};
         tim[1] = tim[1] & ce;
         tim[0] = tim[0] & ce;
         chk("timing",
             {hsync, vsync, valid, line_start, frame_start}, tim);
         if (phase != seen_phase) begin
            seen_phase = phase;
            last_fs = -1;
         end
         if (frame_start && rst_n) begin
            if (exp_period != 0 && last_fs >= 0)
               chk("fs_period", cyc - last_fs, exp_period);
            last_fs = cyc;
         end
      end
   end

   initial begin : stim
      rst_n = 1'b0; ce = 1'b0; win_x = '0; win_y = '0;
      repeat (3) @(negedge clk25);
      #1;
      win_x = 10'd10; win_y = 10'd5;
      rst_n = 1'b1; ce = 1'b1;
      phase = 1; exp_period = FRAME;
      repeat (9000) @(negedge clk25);

      #1;
      phase = 2; exp_period = 2 * FRAME;
      for (int i = 0; i < 18000; i++) begin
         @(negedge clk25); #1;
         ce = ~ce;
         if (i == 7000) begin
            win_x = 10'd60; win_y = 10'd45;
         end
      end

      phase = 3; exp_period = 0;
      for (int i = 0; i < 15000; i++) begin
         @(negedge clk25); #1;
         ce = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 1499) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               win_x = 10'($urandom_range(0, 1023));
               win_y = 10'($urandom_range(0, 1023));
            end else begin
               win_x = 10'($urandom_range(0, 90));
               win_y = 10'($urandom_range(0, 60));
            end
         end
      end

      @(negedge clk25); #1;
      ce = 1'b1;
      repeat (37) @(negedge clk25);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async",
          {x, y, pixel_index, in_window,
           hsync, vsync, valid, line_start, frame_start},
          {27'd0, ~HSP, ~VSP, 3'b000});
      @(negedge clk25); #1;
      win_x = 10'd20; win_y = 10'd10;
      @(negedge clk25); #1;
      rst_n = 1'b1;
      phase = 4; exp_period = FRAME;
      for (int i = 0; i < 9000; i++) begin
         @(negedge clk25); #1;
         if (i == 2000) begin
            win_x = 10'd50; win_y = 10'd40;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
Parameters:
REQ-001 H_ACTIVE, 640, visible pixels per line.
REQ-002 H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 V_ACTIVE, 480, visible lines per frame.
REQ-004 V_FP, 10; V_SYNC, 2; V_BP, 33: vertical front porch, sync and back porch widths in lines.
REQ-005 HS_POL, 0; VS_POL, 0: active level of hsync and vsync.
REQ-006 IMG_W, 64; IMG_H, 48: sprite image size in source pixels.
REQ-007 SCALE_LOG2, 3: sprite upscale factor, 2^SCALE_LOG2 in each axis.
REQ-008 OUT_DELAY, 1, extra ce-stages applied to the timing outputs to match image-memory read latency; 0..7 legal.

Ports (name, direction, width, meaning). Clock and reset: one clock; reset is asynchronous and active-low.
REQ-009 clk25, in, 1, pixel-domain clock.
REQ-010 rst_n, in, 1, asynchronous active-low reset.
REQ-011 ce, in, 1, pixel enable: all state advances only on cycles with ce=1.
REQ-012 win_x, in, 10; win_y, in, 10: sprite window top-left corner in screen pixels.
REQ-013 x, out, 10; y, out, 10: current pixel coordinates.
REQ-014 pixel_index, out, clog2(IMG_W*IMG_H) (12 at defaults): sprite memory address.
REQ-015 in_window, out, 1: current pixel lies inside the visible sprite window.
REQ-016 hsync, out, 1; vsync, out, 1; valid, out, 1: sync signals and active-area flag.
REQ-017 line_start, out, 1; frame_start, out, 1: pulses marking pixel (0,y) and pixel (0,0).

Function
REQ-018 H_TOTAL SHALL be the sum of the four horizontal widths, and V_TOTAL the sum of the four vertical widths; the counters SHALL be h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1.
REQ-019 On each ce cycle, h SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v SHALL increment; v SHALL wrap to 0 at V_TOTAL-1 in the same cycle that h wraps.
REQ-020 Sync SHALL be active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), at the level set by HS_POL/VS_POL.
REQ-021 valid SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-022 x, y, pixel_index and in_window SHALL be registered one ce-stage after the counter value they describe, and SHALL be mutually aligned.
REQ-023 hsync, vsync, valid, line_start and frame_start SHALL appear 1+OUT_DELAY ce-stages after their counter value.
REQ-024 The window span SHALL be IMG_W<<SCALE_LOG2 pixels wide and IMG_H<<SCALE_LOG2 lines high.
REQ-025 in_window SHALL be valid AND wx<=h<wx+span_w AND wy<=v<wy+span_h, using 11-bit compares so that no wrap occurs.
REQ-026 When in_window=1, pixel_index SHALL be ((v-wy)>>SCALE_LOG2)*IMG_W + ((h-wx)>>SCALE_LOG2); otherwise it SHALL be 0.
REQ-027 wx and wy SHALL be shadow copies of win_x and win_y, updated only on the ce cycle with h=H_TOTAL-1 and v=V_TOTAL-1; mid-frame input changes SHALL NOT affect the current frame.
REQ-028 A window extending past the active area SHALL be clipped.
REQ-029 line_start and frame_start SHALL each be high for exactly one clk25 cycle per event, qualified by ce.
REQ-030 While ce=0, the counters and pipeline SHALL hold and the pulses SHALL be 0.

Reset
REQ-031 During rst_n=0, h, v, wx and wy SHALL be 0.
REQ-032 During rst_n=0, x, y and pixel_index SHALL be 0; in_window, valid and the pulses SHALL be 0; syncs SHALL be at their inactive level; delay stages SHALL be cleared to these same values.
REQ-033 After rst_n deasserts, the first ce cycle SHALL process h=0, v=0.
REQ-034 Reset mid-frame SHALL restart timing at (0,0), and the shadow window SHALL read 0 until the first end of frame.

Structure
REQ-035 Package vga_pkg SHALL hold the 640x480@60 timing defaults, the sprite defaults, and a clog2 function.
REQ-036 Sub-module vga_delay_line SHALL be a parametrised-width, parametrised-depth, ce-gated shift register with an asynchronous-clear value; depth 0 SHALL be a wire.

Verification
REQ-037 Defaults, ce=1 continuous: hsync low for exactly 96 clocks per 800-clock line; vsync low for exactly 2 lines per 525-line frame; frame_start every 420000 clocks.
REQ-038 ce toggling 1-0 (50 MHz usage): all period counts double in clocks; each pulse is high for 1 clock only.
REQ-039 win=(100,50), defaults: x=100,y=50 -> index 0; x=107,y=57 -> index 0; x=108,y=58 -> index 65; x=611,y=433 -> index 3071; x=612 -> in_window=0.
REQ-040 win=(600,400): in_window is 0 for x>=640 and y>=480, and no index exceeds 3071.
REQ-041 win_x changed mid-frame: current frame unchanged; next frame uses the new value from frame_start.
REQ-042 OUT_DELAY=3: valid rises 3 ce-stages after in_window; rst_n pulsed mid-line: outputs are at reset values immediately, and timing restarts at (0,0).
